// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// One shared 33-bit adder drives both shift-add multiply and restoring divide.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic [XLEN-1:0] Result,
    output logic            Busy,
    output logic            Done,
    output logic            Stall
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN:0]     add_a, add_b, sum;
    logic              add_cin;
    logic [XLEN-1:0]   hi_n, lo_n;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    // Operand decode, only meaningful in the IDLE accept cycle
    always_comb begin
        sgn_a    = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                   (Funct3 == 3'b100) || (Funct3 == 3'b110);
        sgn_b    = (Funct3 == 3'b001) || (Funct3 == 3'b100) ||
                   (Funct3 == 3'b110);
        a_neg    = sgn_a && SrcA[XLEN-1];
        b_neg    = sgn_b && SrcB[XLEN-1];
        mag_a    = a_neg ? -SrcA : SrcA;
        mag_b    = b_neg ? -SrcB : SrcB;
        div_zero = Funct3[2] && (SrcB == '0);
        div_ovf  = Funct3[2] && !Funct3[0] &&
                   (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
    end

    // The single iteration adder; divide subtracts via inverted operand + carry-in
    always_comb begin
        if (op_q[2]) begin
            add_a   = {hi_q, lo_q[XLEN-1]};
            add_b   = ~{1'b0, b_q};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, hi_q};
            add_b   = lo_q[0] ? {1'b0, b_q} : '0;
            add_cin = 1'b0;
        end
        sum = add_a + add_b + {{XLEN{1'b0}}, add_cin};
    end

    always_comb begin
        if (op_q[2]) begin
            if (!sum[XLEN]) begin
                hi_n = sum[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_n = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo_q[XLEN-1:1]};
        end
        prod     = {hi_n, lo_n};
        prod_fix = neg_q ? -prod : prod;
        quot_fix = neg_q ? -lo_n : lo_n;
        rem_fix  = neg_rem_q ? -hi_n : hi_n;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        op_d      = op_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d = Funct3;
                    if (div_zero || div_ovf) begin
                        state_d = S_DONE;
                        if (Funct3[1])
                            result_d = div_zero ? SrcA : '0;
                        else
                            result_d = div_zero ? '1 : SrcA;
                    end else begin
                        state_d   = S_RUN;
                        cnt_d     = '0;
                        hi_d      = '0;
                        lo_d      = Funct3[2] ? mag_a : mag_b;
                        b_d       = Funct3[2] ? mag_b : mag_a;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                    end
                end
            end
            S_RUN: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (op_q[2])
                        result_d = op_q[1] ? rem_fix : quot_fix;
                    else if (op_q[1:0] == 2'b00)
                        result_d = prod_fix[XLEN-1:0];
                    else
                        result_d = prod_fix[2*XLEN-1:XLEN];
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign Result = result_q;
    assign Busy   = (state_q == S_RUN);
    assign Done   = (state_q == S_DONE);
    assign Stall  = Start && (state_q != S_DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: behavioural RV32M model,
// latency/stall checks per op, reset abort and back-to-back issue.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] Result;
    logic        Busy;
    logic        Done;
    logic        Stall;

    int          n_checks;
    int          n_fail;
    int          done_cnt;
    logic [31:0] sb_q[$];

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Start  (Start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Result (Result),
        .Busy   (Busy),
        .Done   (Done),
        .Stall  (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit special(input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b);
        return (f3[2] && b == 32'h0) ||
               ((f3 == 3'b100 || f3 == 3'b110) &&
                a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f3)
            3'b000: begin p = ua * ub; r = p[31:0];  end
            3'b001: begin p = sa * sb; r = p[63:32]; end
            3'b010: begin p = sa * ub; r = p[63:32]; end
            3'b011: begin p = ua * ub; r = p[63:32]; end
            3'b100: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'h0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && Done) begin
            done_cnt++;
            if (sb_q.size() == 0)
                check("unexpected_done", 64'd1, 64'd0);
            else
                check("result", Result, sb_q.pop_front());
        end
    end

    // Called at a negedge in an IDLE cycle; returns at the DONE negedge if hold
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        int exp_lat;
        int lat;
        int stalls;
        bit seen;
        exp_lat = special(f3, a, b) ? 1 : 33;
        Funct3  = f3;
        SrcA    = a;
        SrcB    = b;
        Start   = 1'b1;
        sb_q.push_back(model(f3, a, b));
        #1;
        stalls = 0;
        lat    = 0;
        seen   = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (Stall) stalls++;
            @(negedge clk);
            lat = c + 1;
            if (Done) seen = 1'b1;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("stall_cycles", 64'(stalls), 64'(exp_lat));
        check("stall_in_done", 64'(Stall), 64'd0);
        if (!hold) begin
            Start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        n_checks = 0;
        n_fail   = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        Start    = 1'b1;
        Funct3   = 3'b000;
        SrcA     = '0;
        SrcB     = '0;
        #3;
        check("rst_result", Result, 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_stall_hi", 64'(Stall), 64'd1);
        Start = 1'b0;
        #1;
        check("rst_stall_lo", 64'(Stall), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'b000, 32'd7, 32'd6, 1'b0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b100, -32'sd7, 32'd2, 1'b0);
        run_op(3'b110, -32'sd7, 32'd2, 1'b0);
        run_op(3'b101, 32'd100, 32'd7, 1'b0);
        run_op(3'b111, 32'd100, 32'd7, 1'b0);
        run_op(3'b101, 32'd5, 32'd0, 1'b0);
        run_op(3'b110, 32'd5, 32'd0, 1'b0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b000, -32'sd5, 32'd7, 1'b0);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(3'b100, 32'd7, -32'sd2, 1'b0);
        run_op(3'b110, 32'd7, -32'sd2, 1'b0);

        for (int i = 0; i < 8; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op(f3, a, b, 1'b0);
        end

        // Reset in the middle of a multiply
        Funct3 = 3'b000;
        SrcA   = 32'd123;
        SrcB   = 32'd456;
        Start  = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_run_busy", 64'(Busy), 64'd1);
        rst_n = 1'b0;
        Start = 1'b0;
        #1;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_result", Result, 64'd0);
        check("abort_done", 64'(Done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(3'b000, 32'd3, 32'd3, 1'b0);

        // Back-to-back with Start held through DONE
        d0 = done_cnt;
        run_op(3'b000, 32'd5, 32'd6, 1'b1);
        @(negedge clk);
        check("b2b_idle_busy", 64'(Busy), 64'd0);
        check("b2b_idle_done", 64'(Done), 64'd0);
        check("b2b_idle_stall", 64'(Stall), 64'd1);
        run_op(3'b101, 32'd100, 32'd7, 1'b0);
        check("b2b_done_pulses", 64'(done_cnt - d0), 64'd2);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
